self_trig_rec: RTL
==================

# self_trig_rec

Self-trigger waveform recorder for one WFD125 channel. It is the consumer of the self-trigger pulse and trigger counter: it keeps a running history of pedestal-subtracted ADC samples, and on each accepted trigger it freezes a pre/post window around the trigger. It then streams a header plus the window to the channel's output FIFO over a valid/ready handshake. While it is busy it asserts `busy`, which the channel logic ORs into the self-trigger inhibit.

## Interface
- `HBITS`, 9, history buffer address width; depth is 2^HBITS samples of 16 bits.
- `adcclk`  in  1  ADC clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  16  signed ADC sample after pedestal subtraction; written every unfrozen cycle.
- `trig`  in  1  self-trigger, a 1-cycle pulse.
- `counter`  in  10  trigger counter; sampled in the same cycle as `trig`.
- `chan_id`  in  5  channel number placed in the header.
- `presamples`  in  HBITS-1  samples before the trigger sample; sampled at trigger.
- `postsamples`  in  HBITS-1  samples from the trigger sample onward; sampled at trigger.
- `dout`  out  16  stream word.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  downstream accepts the word.
- `dout_first`  out  1  marks header word 0.
- `dout_last`  out  1  marks the final word of the frame.
- `busy`  out  1  high whenever the state is not IDLE.
- `dropped`  out  16  count of triggers received while not IDLE; saturates at 16'hFFFF.

## Operation
- States: REFILL, IDLE, POST, HDR, DATA.
- **REFILL**
  - History writes are on.
  - Counts `presamples` written samples, then moves to IDLE.
  - Reset enters REFILL. On reset `presamples` is read live until the count completes.
- **IDLE**
  - Writes are on.
  - `trig`=1 latches `counter`, `presamples` and `postsamples` into P and Q.
  - It also latches A, the write address used in the same cycle, and goes to POST.
- **POST**
  - Writes continue until the sample at address A+Q-1 has been written.
  - Writing then freezes and the state moves to HDR.
  - If Q=0, writing freezes from the cycle after the trigger.
- **HDR**
  - Header word 0 = {1'b1, `chan_id`, latched counter}.
  - Header word 1 = {5'b0, N}, where N = P+Q (HBITS bits, zero-extended to 11).
  - If N=0, the frame is header only: word 1 carries `dout_last` and the state goes to REFILL.
- **DATA**
  - Emits N samples from buffer addresses A-P to A+Q-1, oldest first.
  - Address arithmetic is modulo 2^HBITS. A-P wraps below 0.
  - The last sample carries `dout_last`. After it is accepted, writing resumes and the state goes to REFILL.
- **Handshake**
  - A word transfers only in a cycle where `dout_valid`=1 and `dout_ready`=1.
  - `dout`, `dout_first` and `dout_last` hold stable while `dout_valid`=1 and `dout_ready`=0.
  - `dout_valid` does not depend combinationally on `dout_ready`.
- **Dropped triggers**
  - `trig` in any state other than IDLE increments `dropped` and is otherwise ignored.
- **Capacity**
  - Because `presamples` and `postsamples` are each HBITS-1 bits wide, N ≤ 2^HBITS-2.
  - The frozen window therefore never overlaps itself.

## Timing
- **Reset values:**
  - `dout`=0, `dout_valid`=0, `dout_first`=0, `dout_last`=0.
  - `busy`=1 (REFILL), `dropped`=0, write address 0.
- **Reset mid-frame:** the frame is aborted and `dout_valid` drops in the next cycle. The downstream FIFO is reset by the same signal.
- **Trigger capture:** trigger accepted at cycle T → POST from T+1. The last write is at cycle T+Q-1. HDR is entered at T+Q, with T+1 used when Q=0.
- **First header word:** `dout_valid` with word 0 rises 1 cycle after HDR is entered.
- **Sustained rate:** with `dout_ready` held at 1, one word is transferred per cycle across the whole frame, including the HDR→DATA boundary.
  - The synchronous buffer read is prefetched so that DATA has no bubbles.
- **Re-arm:** REFILL is entered in the cycle after the last word is accepted. IDLE is reached P cycles later, or the next cycle when P=0.
- **`busy`:** a registered decode of the state, with no extra delay.
- **Simultaneous events:**
  - `trig` in the same cycle that REFILL finishes counting is dropped, because the state is still REFILL.
  - `trig` in the cycle that IDLE is entered is accepted.

## Configuration
- **`STREC_TSTAMP_EN`**
  - Defined: a 32-bit free-running `adcclk` counter is added, reset to 0 by `reset`. Its value is latched at the trigger cycle.
  - Two header words are inserted after word 0: timestamp[31:16], then timestamp[15:0]. The header becomes 4 words.
  - Undefined: there is no counter and the header is 2 words.
  - All timing figures are otherwise unchanged.

## Test plan
- **Basic frame:** `data` is a ramp (value = cycle number), P=4, Q=8, `chan_id`=3, and `trig` arrives with `counter`=0x155 while `dout_ready`=1.
  - Expected: 0x8000|(3<<10)|0x155, then 12, then 12 consecutive ramp values starting 4 before the trigger sample. `dout_last` is on the 12th sample.
- **Wrap:** HBITS=9, trigger at write address 2, P=10.
  - Expected: samples are read from addresses 504..511 then 0..; the stream is contiguous and correct.
- **Backpressure:** toggle `dout_ready` pseudo-randomly.
  - Expected: identical word sequence with no duplicates or losses, and words held stable while stalled.
- **Dropped triggers:** 3 `trig` pulses during POST/DATA, plus 1 in the final REFILL cycle.
  - Expected: `dropped`=4 and exactly one frame emitted.
- **Zero and maximum windows:** P=Q=0 gives two header words, with N=0 and `dout_last` on word 1. P=Q=255 gives N=510 with a correct sample sequence.
- **Reset and timestamp:** `reset` in the middle of DATA gives `dout_valid`=0 in the next cycle, then REFILL and `busy`=1. With `STREC_TSTAMP_EN` defined, a trigger 1000 cycles after reset yields timestamp words 0x0000 and 1000.

Source files
------------

// File: rtl/self_trig_rec.sv
// Self-trigger waveform recorder: pre/post trigger window capture streamed as header + samples.
// Optional STREC_TSTAMP_EN adds a 32-bit trigger timestamp (two extra header words).
module self_trig_rec #(
   parameter int unsigned HBITS = 9
) (
   input  logic             adcclk,
   input  logic             reset,
   input  logic [15:0]      data,
   input  logic             trig,
   input  logic [9:0]       counter,
   input  logic [4:0]       chan_id,
   input  logic [HBITS-2:0] presamples,
   input  logic [HBITS-2:0] postsamples,
   output logic [15:0]      dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_first,
   output logic             dout_last,
   output logic             busy,
   output logic [15:0]      dropped
);

   localparam int unsigned DEPTH = 1 << HBITS;
`ifdef STREC_TSTAMP_EN
   localparam logic [1:0] HLAST = 2'd3;
`else
   localparam logic [1:0] HLAST = 2'd1;
`endif

   typedef enum logic [2:0] {REFILL, IDLE, POST, HDR, DATA} state_t;
   state_t state, state_nx;

   logic [15:0]      mem [DEPTH];
   logic [15:0]      rd_q;
   logic [HBITS-1:0] wr_addr, a_q, ptr, raddr, n_q, scnt, rcnt;
   logic [HBITS-1:0] last_addr, refill_tgt;
   logic [HBITS-2:0] p_q, q_q;
   logic [9:0]       cnt_q;
   logic [1:0]       hidx;
   logic             live_q;
   logic             we, adv, load_hdr, load_smp, xfer_last, refill_done;
   logic [15:0]      hdr_word, n_word;

`ifdef STREC_TSTAMP_EN
   logic [31:0] ts, ts_q;

   always_ff @(posedge adcclk) begin
      if (reset) begin
         ts   <= '0;
         ts_q <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (state == IDLE && trig) ts_q <= ts;
      end
   end
`endif

   always_comb begin
      we          = (state == REFILL) || (state == IDLE) || (state == POST);
      adv         = !dout_valid || dout_ready;
      load_hdr    = (state == HDR) && adv;
      load_smp    = (state == DATA) && adv && (scnt != n_q);
      xfer_last   = dout_valid && dout_ready && dout_last;
      refill_tgt  = live_q ? {1'b0, presamples} : {1'b0, p_q};
      refill_done = (rcnt + 1'b1) >= refill_tgt;
      last_addr   = a_q + {1'b0, q_q} - 1'b1;
      // ptr always holds the next sample to emit; rd_q is its prefetched contents
      raddr       = load_smp ? ptr + 1'b1 : ptr;
      n_word      = {{(16-HBITS){1'b0}}, n_q};
      case (hidx)
         2'd0:    hdr_word = {1'b1, chan_id, cnt_q};
`ifdef STREC_TSTAMP_EN
         2'd1:    hdr_word = ts_q[31:16];
         2'd2:    hdr_word = ts_q[15:0];
         2'd3:    hdr_word = n_word;
`else
         2'd1:    hdr_word = n_word;
`endif
         default: hdr_word = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         REFILL: if (refill_done) state_nx = IDLE;
         IDLE:   if (trig) state_nx = (postsamples[HBITS-2:1] == '0) ? HDR : POST;
         POST:   if (wr_addr == last_addr) state_nx = HDR;
         HDR:    if (adv && hidx == HLAST) state_nx = DATA;
         DATA:   if (xfer_last) state_nx = REFILL;
         default: state_nx = REFILL;
      endcase
   end

   always_ff @(posedge adcclk) begin
      if (reset) begin
         state <= REFILL;
         busy  <= 1'b1;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
      end
   end

   always_ff @(posedge adcclk) begin
      if (we) mem[wr_addr] <= data;
      rd_q <= mem[raddr];
   end

   always_ff @(posedge adcclk) begin
      if (reset) begin
         wr_addr    <= '0;
         rcnt       <= '0;
         live_q     <= 1'b1;
         dropped    <= '0;
         a_q        <= '0;
         ptr        <= '0;
         n_q        <= '0;
         scnt       <= '0;
         p_q        <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         hidx       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_first <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         if (we) wr_addr <= wr_addr + 1'b1;
         rcnt <= (state == REFILL) ? rcnt + 1'b1 : '0;
         if (state == REFILL && refill_done) live_q <= 1'b0;
         if (trig && state != IDLE && dropped != '1) dropped <= dropped + 1'b1;

         if (state == IDLE && trig) begin
            cnt_q <= counter;
            p_q   <= presamples;
            q_q   <= postsamples;
            a_q   <= wr_addr;
            ptr   <= wr_addr - {1'b0, presamples};
            n_q   <= {1'b0, presamples} + {1'b0, postsamples};
            hidx  <= '0;
            scnt  <= '0;
         end else begin
            ptr <= raddr;
         end

         if (load_hdr) begin
            hidx       <= hidx + 1'b1;
            dout       <= hdr_word;
            dout_valid <= 1'b1;
            dout_first <= (hidx == 2'd0);
            dout_last  <= (hidx == HLAST) && (n_q == '0);
         end else if (load_smp) begin
            scnt       <= scnt + 1'b1;
            dout       <= rd_q;
            dout_valid <= 1'b1;
            dout_first <= 1'b0;
            dout_last  <= (scnt == n_q - 1'b1);
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule
